// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared constants and types for the receive-side TDM demultiplexer.
//   NCH     : number of time slots (channels) per frame
//   SEL_W   : width of the slot index
//   state_e : framing state machine encoding (HUNT / LOCK)
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_demux_1to8_decoder_3to8.sv
// -----------------------------------------------------------------------------
// decoder_3to8
// Combinational one-hot decoder that turns the slot index into per-slot
// shadow load strobes. Mirrors the select decode of the transmit-side mux.
//   en_i   : write enable; all strobes are low when deasserted
//   sel_i  : slot index to strobe
//   strb_o : one-hot load strobes, bit k loads shadow slot k
// -----------------------------------------------------------------------------
module decoder_3to8
    import tdm_pkg::*;
(
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [NCH-1:0]   strb_o
);

    always_comb begin
        strb_o = '0;
        if (en_i) begin
            strb_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1to8.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to8
// Receive-side 1-to-8 time-division demultiplexer. Serial samples are
// accumulated slot by slot into a shadow register; when slot 7 is written the
// complete frame is copied to dout together with a one-cycle dout_valid pulse,
// so dout never shows a partial frame.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   din        : W-bit sample for the current slot
//   din_valid  : din / sync are meaningful this cycle
//   sync       : marks a channel-0 sample (only looked at with din_valid)
//   dout       : last complete frame, channel k at dout[k*W +: W]
//   dout_valid : one-cycle pulse when dout updates
//   ch_sel     : slot the next valid sample will be written to
//   locked     : high while the framer is in LOCK
//   sync_err   : one-cycle pulse on a framing violation
//
// Build option:
//   TDM_SYNC_CHECK_EN : when defined, sync is also checked in LOCK. A sync on a
//   non-zero slot realigns to slot 0 and flags sync_err; a missing sync on slot
//   0 flags sync_err, drops the sample and returns to HUNT. When undefined,
//   LOCK free-runs on din_valid and sync_err is tied low.
// -----------------------------------------------------------------------------
module tdm_demux_1to8
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       din,
    input  logic               din_valid,
    input  logic               sync,
    output logic [NCH*W-1:0]   dout,
    output logic               dout_valid,
    output logic [SEL_W-1:0]   ch_sel,
    output logic               locked,
    output logic               sync_err
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);

    state_e             state_q,      state_d;
    logic [SEL_W-1:0]   ch_sel_q,     ch_sel_d;
    logic [NCH*W-1:0]   shadow_q,     shadow_d;
    logic [NCH*W-1:0]   dout_q,       dout_d;
    logic               dout_valid_q, dout_valid_d;

    logic               wr_en;
    logic [SEL_W-1:0]   wr_sel;
    logic [NCH-1:0]     wr_strb;
    logic               frame_done;

`ifdef TDM_SYNC_CHECK_EN
    logic               sync_err_q,   sync_err_d;
`endif

    // Framing control: decides which slot (if any) this sample lands in and
    // whether it closes a frame.
    always_comb begin
        state_d    = state_q;
        ch_sel_d   = ch_sel_q;
        wr_en      = 1'b0;
        wr_sel     = ch_sel_q;
        frame_done = 1'b0;
`ifdef TDM_SYNC_CHECK_EN
        sync_err_d = 1'b0;
`endif
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        wr_en    = 1'b1;
                        wr_sel   = '0;
                        ch_sel_d = SEL_W'(1);
                        state_d  = LOCK;
                    end
                end
                LOCK: begin
`ifdef TDM_SYNC_CHECK_EN
                    if (sync && (ch_sel_q != '0)) begin
                        // Early sync: abandon the partial frame and restart
                        // it with this sample as slot 0. Stale shadow slots
                        // are overwritten before the next frame closes.
                        sync_err_d = 1'b1;
                        wr_en      = 1'b1;
                        wr_sel     = '0;
                        ch_sel_d   = SEL_W'(1);
                    end else if (!sync && (ch_sel_q == '0)) begin
                        // Missing sync on slot 0: alignment lost.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        wr_en      = 1'b1;
                        ch_sel_d   = ch_sel_q + SEL_W'(1);
                        frame_done = (ch_sel_q == LAST_SLOT);
                    end
`else
                    wr_en      = 1'b1;
                    ch_sel_d   = ch_sel_q + SEL_W'(1);
                    frame_done = (ch_sel_q == LAST_SLOT);
`endif
                end
                default: begin
                    state_d  = HUNT;
                    ch_sel_d = '0;
                end
            endcase
        end
    end

    decoder_3to8 u_dec (
        .en_i   (wr_en),
        .sel_i  (wr_sel),
        .strb_o (wr_strb)
    );

    // Shadow load; the output copy takes the updated shadow so that slot 7
    // written on this edge is part of the published frame.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NCH; k++) begin
            if (wr_strb[k]) begin
                shadow_d[k*W +: W] = din;
            end
        end
        dout_d       = frame_done ? shadow_d : dout_q;
        dout_valid_d = frame_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            ch_sel_q     <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
`ifdef TDM_SYNC_CHECK_EN
            sync_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ch_sel_q     <= ch_sel_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
`ifdef TDM_SYNC_CHECK_EN
            sync_err_q   <= sync_err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ch_sel     = ch_sel_q;
    assign locked     = (state_q == LOCK);
`ifdef TDM_SYNC_CHECK_EN
    assign sync_err   = sync_err_q;
`else
    assign sync_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1to8
// Self-checking bench for tdm_demux_1to8 with W=4. A frame-level reference
// model (slot array + lock flag) predicts every output after each clock.
// Expectations follow TDM_SYNC_CHECK_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1to8;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          sync;
    logic [8*W-1:0] dout;
    logic          dout_valid;
    logic [2:0]    ch_sel;
    logic          locked;
    logic          sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    tdm_demux_1to8 #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ch_sel     (ch_sel),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit             m_lock;
    int             m_slot;
    logic [W-1:0]   m_frame [8];
    logic [8*W-1:0] m_dout;
    bit             m_dv;
    bit             m_err;

    function automatic void model_reset();
        m_lock = 0;
        m_slot = 0;
        for (int k = 0; k < 8; k++) m_frame[k] = '0;
        m_dout = '0;
        m_dv   = 0;
        m_err  = 0;
    endfunction

    function automatic void model_step(input bit v, input bit s, input logic [W-1:0] d);
        m_dv  = 0;
        m_err = 0;
        if (!v) return;
        if (!m_lock) begin
            if (s) begin
                m_frame[0] = d;
                m_slot     = 1;
                m_lock     = 1;
            end
            return;
        end
`ifdef TDM_SYNC_CHECK_EN
        if (s && m_slot != 0) begin
            m_err      = 1;
            m_frame[0] = d;
            m_slot     = 1;
            return;
        end
        if (!s && m_slot == 0) begin
            m_err  = 1;
            m_lock = 0;
            return;
        end
`endif
        m_frame[m_slot] = d;
        if (m_slot == 7) begin
            for (int k = 0; k < 8; k++) m_dout[k*W +: W] = m_frame[k];
            m_dv = 1;
        end
        m_slot = (m_slot + 1) % 8;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("dout",       dout,        m_dout);
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_dv});
        chk("ch_sel",     {29'd0, ch_sel},     m_slot[31:0]);
        chk("locked",     {31'd0, locked},     {31'd0, m_lock});
        chk("sync_err",   {31'd0, sync_err},   {31'd0, m_err});
    endtask

    // Called at posedge+1: drive, take one edge, compare at posedge+1.
    task automatic step(input bit v, input bit s, input logic [W-1:0] d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
        model_step(v, s, d);
        chk_model();
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
    task automatic async_reset(input string tag);
        din_valid = 1'b0;
        sync      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_dout"},     dout,                  32'd0);
        chk({tag, "_dv"},       {31'd0, dout_valid},   32'd0);
        chk({tag, "_ch_sel"},   {29'd0, ch_sel},       32'd0);
        chk({tag, "_locked"},   {31'd0, locked},       32'd0);
        chk({tag, "_sync_err"}, {31'd0, sync_err},     32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic           v;
        logic           s;
        logic [W-1:0]   d;
        logic [2:0]     ch;
        logic           lk;
        logic           dv;
        logic [8*W-1:0] dout;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Unsynced samples ignored, lock on sync, 3-cycle gap between slots
        // 2 and 3 (one gap cycle carries sync with din_valid low), frame out.
        tbl[0]  = '{1'b1, 1'b0, 4'h9, 3'd0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 4'hA, 3'd0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 4'hB, 3'd0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 4'h1, 3'd1, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 4'h2, 3'd2, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 4'h3, 3'd3, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 4'hF, 3'd3, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 4'hE, 3'd3, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 4'hD, 3'd3, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 4'h4, 3'd4, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 4'h5, 3'd5, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 4'h6, 3'd6, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 4'h7, 3'd7, 1'b1, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 4'h8, 3'd0, 1'b1, 1'b1, 32'h87654321};
        tbl[14] = '{1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 1'b0, 32'h87654321};

        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sync      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout",   dout,                32'd0);
        chk("rst_dv",     {31'd0, dout_valid}, 32'd0);
        chk("rst_ch_sel", {29'd0, ch_sel},     32'd0);
        chk("rst_locked", {31'd0, locked},     32'd0);
        chk("rst_err",    {31'd0, sync_err},   32'd0);
        rst_n = 1'b1;
        #2;

        // ---- table-driven frame with gap ----
        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            chk($sformatf("tbl%0d_ch", i),   {29'd0, ch_sel},     {29'd0, tbl[i].ch});
            chk($sformatf("tbl%0d_lk", i),   {31'd0, locked},     {31'd0, tbl[i].lk});
            chk($sformatf("tbl%0d_dv", i),   {31'd0, dout_valid}, {31'd0, tbl[i].dv});
            chk($sformatf("tbl%0d_dout", i), dout,                tbl[i].dout);
            chk($sformatf("tbl%0d_err", i),  {31'd0, sync_err},   32'd0);
        end

        // ---- reset asserted mid-run with a frame on dout ----
        async_reset("midrst");

        // ---- early sync at ch_sel=5 ----
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, 4'(i + 1));
        chk("pre_resync_dout", dout, 32'h87654321);
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 4'(i + 1));
        chk("at_ch5", {29'd0, ch_sel}, 32'd5);
        step(1'b1, 1'b1, 4'hA);
`ifdef TDM_SYNC_CHECK_EN
        chk("resync_err",  {31'd0, sync_err}, 32'd1);
        chk("resync_ch",   {29'd0, ch_sel},   32'd1);
        chk("resync_dout", dout,              32'h87654321);
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 4'(i));
        chk("resync_frame_dv",   {31'd0, dout_valid}, 32'd1);
        chk("resync_frame_dout", dout,                32'h7654321A);
`else
        chk("nochk_resync_err", {31'd0, sync_err}, 32'd0);
        chk("nochk_resync_ch",  {29'd0, ch_sel},   32'd6);
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        chk("nochk_frame_dv",   {31'd0, dout_valid}, 32'd1);
        chk("nochk_frame_dout", dout,                32'h21A54321);
`endif

        // ---- missing sync at slot 0 while locked ----
        async_reset("rst2");
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, 4'(8 - i));
        chk("lost_pre_ch", {29'd0, ch_sel}, 32'd0);
        step(1'b1, 1'b0, 4'hC);
`ifdef TDM_SYNC_CHECK_EN
        chk("lost_err",    {31'd0, sync_err}, 32'd1);
        chk("lost_locked", {31'd0, locked},   32'd0);
        chk("lost_ch",     {29'd0, ch_sel},   32'd0);
        step(1'b0, 1'b0, 4'h0);
        chk("lost_err_pulse", {31'd0, sync_err}, 32'd0);
`else
        chk("nochk_lost_err",    {31'd0, sync_err}, 32'd0);
        chk("nochk_lost_locked", {31'd0, locked},   32'd1);
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 4'(i));
        chk("nochk_lost_dv",   {31'd0, dout_valid}, 32'd1);
        chk("nochk_lost_dout", dout,                32'h7654321C);
`endif

        // ---- randomized traffic against the model ----
        async_reset("rst3");
        for (int i = 0; i < 3000; i++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 9) == 0);
            step(v, s, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1to8.md
# tdm_demux_1to8

Receive-side time-division demultiplexer: takes one serial channel stream produced by the 8-to-1 multiplexer path and distributes successive samples into eight per-channel registers. A sync flag aligns on channel 0. The block publishes a complete 8-channel frame with a one-cycle valid pulse. It sits at the far end of the TDM link, feeding per-channel consumers.

## Interface
- `W`, default 1: per-channel sample width in bits.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `din`, input, W: sample for the current slot.
- `din_valid`, input, 1: `din` and `sync` are meaningful this cycle.
- `sync`, input, 1: marks a channel-0 sample; only sampled when `din_valid=1`.
- `dout`, output, 8*W: last complete frame; channel k is at `dout[k*W +: W]`.
- `dout_valid`, output, 1: one-cycle pulse when `dout` updates.
- `ch_sel`, output, 3: slot index the next valid sample will be written to.
- `locked`, output, 1: high while in state LOCK.
- `sync_err`, output, 1: one-cycle pulse on a framing violation.

## Operation
- **State machine, HUNT / LOCK.** Reset enters HUNT.
- **HUNT.**
  - Samples with `sync=0` are discarded; `ch_sel` stays 0.
  - `din_valid & sync` writes slot 0, sets `ch_sel=1` and moves to LOCK.
- **LOCK.**
  - Each `din_valid` writes `din` into shadow slot `ch_sel`, then `ch_sel` increments mod 8 (7 wraps to 0).
  - A write to slot 7 copies the whole shadow into `dout` and pulses `dout_valid`.
- **Shadow register.** Slots are accumulated in an 8*W shadow register, so `dout` never shows a partial frame.
- **Mid-frame sync** (`sync=1` while `ch_sel≠0` in LOCK), with the macro enabled:
  - `sync_err` pulses and the partial frame is abandoned.
  - The sample is written as slot 0 and `ch_sel` becomes 1.
  - `dout` is not updated.
- **`din_valid=0`.** Nothing changes; gaps of any length inside a frame are legal.
- **Reset mid-frame.** The partial frame is lost; `dout` clears to 0.

## Timing
- **Reset values:** `dout=0`, `dout_valid=0`, `ch_sel=0`, `locked=0`, `sync_err=0`, state HUNT, shadow=0.
- **Write latency:** a sample with `din_valid` high at edge n is visible in the shadow after edge n.
- **Frame latency:** `dout` and `dout_valid` change on the same edge that captures slot 7, so they are visible the cycle after the slot-7 `din_valid`.
- **`dout` hold:** `dout` holds until the next complete frame.
- **Throughput:** back-to-back `din_valid` gives one frame per 8 cycles; consecutive `dout_valid` pulses are at least 8 cycles apart.
- **Error flag:** `sync_err` is registered and asserts the cycle after the offending sample.

## Configuration
- **`TDM_SYNC_CHECK_EN` defined:**
  - Mid-frame sync raises `sync_err` and realigns, as described under Operation.
  - A valid sample with `sync=0` at `ch_sel=0` in LOCK pulses `sync_err`, discards the sample and returns to HUNT (`locked=0`).
- **`TDM_SYNC_CHECK_EN` undefined:**
  - `sync` is examined only in HUNT.
  - LOCK free-runs on `din_valid` and never leaves except by reset.
  - `sync_err` is tied to 0.

## Structure
- **Package `tdm_pkg`:** `NCH=8`, `SEL_W=3`, and the state enum `{HUNT, LOCK}`.
- **Sub-module `decoder_3to8`:** a combinational one-hot decoder of `ch_sel`, gated by the write enable, that drives the per-slot shadow load strobes. It mirrors the mux select decode on the transmit side.
- **Top level:** state register, counter, shadow and output registers.

## Test plan
- Reset asserted mid-run -> all outputs 0 and `locked=0` on the same cycle, asynchronously.
- `W=4`, `sync` on the first valid sample, then slots 0..7 = 0x1..0x8 back-to-back -> one `dout_valid` pulse on the cycle after slot 7, with `dout=0x87654321`.
- Same frame with `din_valid` low for 3 cycles between slots 2 and 3 -> the same `dout`, with `dout_valid` delayed by 3 cycles and `ch_sel` held at 3 during the gap.
- Three samples with `sync=0` before any sync -> they are ignored, `locked=0` and `ch_sel=0`; lock occurs on the first sync sample.
- Macro on: `sync=1` at `ch_sel=5` -> `sync_err` pulses, `ch_sel=1`, `dout` unchanged; the next 7 samples complete a frame whose slot 0 is the resync sample.
- Macro on: `sync=0` at slot 0 in LOCK -> `sync_err` pulses and `locked` drops.
- Macro off: the same two stimuli -> `sync_err` stays 0 and the frame is still emitted on count.
